// File: rtl/display_scan_pkg.sv
// Shared register map, field offsets and segment glyphs for the multiplexed display scanner.
package display_scan_pkg;

  localparam logic ADDR_DIGITS = 1'b0;
  localparam logic ADDR_CTRL   = 1'b1;

  localparam int unsigned BUS_W        = 32;
  localparam int unsigned CTRL_W       = 28;
  localparam int unsigned CTRL_FMT_BIT = 24;
  localparam int unsigned RD_OVF_BIT   = 30;
  localparam int unsigned RD_BUSY_BIT  = 31;

  // CTRL layout: [27:25] brightness, [24] format, [23:16] blink, [15:8] dp, [7:0] enable
  typedef struct packed {
    logic [2:0] bright;
    logic       fmt;
    logic [7:0] blink;
    logic [7:0] dp;
    logic [7:0] en;
  } ctrl_t;

  // Active-high gfedcba glyphs for hex 0..F; the pins are active-low so users invert.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SEG_DASH    = 7'h40;
  localparam logic [6:0] SEG_BLANK_N = 7'h7F;

  function automatic logic [6:0] seg_decode_n(input logic [3:0] nib);
    return ~SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/peripheral_display_scan_if.sv
// Host register bus of the display scanner: register select, write data/strobe, readback.
interface peripheral_display_scan_if;
  import display_scan_pkg::*;

  logic             A;
  logic [BUS_W-1:0] WD;
  logic             WE;
  logic [BUS_W-1:0] RD;

  modport master (output A, output WD, output WE, input RD);
  modport slave  (input A, input WD, input WE, output RD);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one source bit per cycle, 4*NUM_DIGITS cycles per value.
// Restartable while busy; result and overflow are presented combinationally on the done cycle.
module bin2bcd_seq #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  output logic                    busy_o,
  output logic                    done_c_o,
  output logic [4*NUM_DIGITS-1:0] bcd_c_o,
  output logic                    ovf_c_o
);

  localparam int unsigned W      = 4 * NUM_DIGITS;
  localparam int unsigned STEP_W = $clog2(W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      bin_q, bin_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      adj_c;
  logic              sticky_q, sticky_d;
  logic [STEP_W-1:0] step_q, step_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      step_q   <= step_d;
    end
  end

  // Add-3 on every BCD digit that would reach ten or more after the next shift
  always_comb begin
    adj_c = acc_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // A bit shifted out of the top digit means the value needs more than NUM_DIGITS digits
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    step_d   = step_q;
    done_c_o = 1'b0;
    if (state_q == S_SHIFT) begin
      bin_d    = bin_q << 1;
      acc_d    = {adj_c[W-2:0], bin_q[W-1]};
      sticky_d = sticky_q | adj_c[W-1];
      step_d   = step_q + STEP_W'(1);
      if (step_q == LAST_STEP) begin
        state_d  = S_IDLE;
        done_c_o = 1'b1;
      end
    end
    if (start_i) begin
      state_d  = S_SHIFT;
      bin_d    = value_i;
      acc_d    = '0;
      sticky_d = 1'b0;
      step_d   = '0;
      done_c_o = 1'b0;
    end
  end

  assign busy_o  = (state_q == S_SHIFT);
  assign bcd_c_o = {adj_c[W-2:0], bin_q[W-1]};
  assign ovf_c_o = sticky_q | adj_c[W-1];

endmodule

// File: rtl/peripheral_display_scan.sv
// Multiplexed 7-segment scanner with DIGITS/CTRL registers, brightness PWM and binary-to-BCD mode.
// Digit blinking is compiled in only when DISPLAY_SCAN_BLINK_EN is defined.
module peripheral_display_scan
  import display_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  peripheral_display_scan_if.slave  bus,
  output logic [6:0]                display,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     selector
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DW-1:0]         digits_q, digits_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [DW-1:0]         shadow_q;
  logic                  ovf_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  slot_end_c;
  logic                  start_c;
  logic [DW-1:0]         conv_val_c;
  logic                  conv_busy, conv_done_c, conv_ovf_c;
  logic [DW-1:0]         conv_bcd_c;
  logic [3:0]            nib_c;
  logic                  en_bit_c, dp_bit_c, blink_bit_c, blink_off_c, drive_c;
  logic [31:0]           on_cycles_c;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [6:0]            disp_q, disp_d;
  logic                  dp_q, dp_d;
  logic                  unused_wd;

  assign unused_wd = ^bus.WD;

  // Register writes and conversion launch (format is judged on its value before the write)
  always_comb begin
    digits_d   = digits_q;
    ctrl_d     = ctrl_q;
    start_c    = 1'b0;
    conv_val_c = digits_q;
    if (bus.WE) begin
      if (bus.A == ADDR_DIGITS) begin
        digits_d = bus.WD[DW-1:0];
        if (ctrl_q.fmt) begin
          start_c    = 1'b1;
          conv_val_c = bus.WD[DW-1:0];
        end
      end else begin
        ctrl_d = ctrl_t'(bus.WD[CTRL_W-1:0]);
        if (!ctrl_q.fmt && bus.WD[CTRL_FMT_BIT]) start_c = 1'b1;
      end
    end
  end

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_c),
    .value_i  (conv_val_c),
    .busy_o   (conv_busy),
    .done_c_o (conv_done_c),
    .bcd_c_o  (conv_bcd_c),
    .ovf_c_o  (conv_ovf_c)
  );

  // Slot prescaler and digit index
  always_comb begin
    slot_end_c = (cnt_q == CNT_LAST);
    cnt_d      = slot_end_c ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_end_c) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_q;
  logic            phase_q;
  logic            frame_end_c;

  assign frame_end_c = slot_end_c && (idx_q == IDX_LAST);

  // Blink phase flips after every BLINK_FRAMES complete scan frames
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_end_c) begin
      if (frame_q == FR_LAST) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FR_W'(1);
      end
    end
  end

  assign blink_off_c = phase_q & blink_bit_c;
`else
  logic unused_blink;
  assign blink_off_c  = 1'b0;
  assign unused_blink = ^{blink_bit_c, 32'(BLINK_FRAMES)};
`endif

  // Next registered segment/anode values for the current slot
  always_comb begin
    nib_c       = '0;
    en_bit_c    = 1'b0;
    dp_bit_c    = 1'b0;
    blink_bit_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c       = ctrl_q.fmt ? shadow_q[4*i +: 4] : digits_q[4*i +: 4];
        en_bit_c    = ctrl_q.en[i];
        dp_bit_c    = ctrl_q.dp[i];
        blink_bit_c = ctrl_q.blink[i];
      end
    end
    on_cycles_c = ((32'(ctrl_q.bright) + 32'd1) * SCAN_DIV) >> 3;
    drive_c     = en_bit_c && !blink_off_c && (32'(cnt_q) < on_cycles_c);
    sel_d       = '1;
    disp_d      = SEG_BLANK_N;
    dp_d        = 1'b1;
    if (drive_c) begin
      sel_d  = ~(NUM_DIGITS'(1) << idx_q);
      disp_d = (ctrl_q.fmt && ovf_q) ? ~SEG_DASH : seg_decode_n(nib_c);
      dp_d   = ~dp_bit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      ctrl_q   <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '1;
      disp_q   <= SEG_BLANK_N;
      dp_q     <= 1'b1;
    end else begin
      digits_q <= digits_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      disp_q   <= disp_d;
      dp_q     <= dp_d;
      if (conv_done_c) begin
        shadow_q <= conv_bcd_c;
        ovf_q    <= conv_ovf_c;
      end
    end
  end

  // Combinational readback of the selected register
  always_comb begin
    bus.RD = '0;
    if (bus.A == ADDR_CTRL) begin
      bus.RD[CTRL_W-1:0]  = ctrl_q;
      bus.RD[RD_OVF_BIT]  = ovf_q;
      bus.RD[RD_BUSY_BIT] = conv_busy;
    end else begin
      bus.RD[DW-1:0] = digits_q;
    end
  end

  assign selector = sel_q;
  assign display  = disp_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_peripheral_display_scan.sv
// Bench for peripheral_display_scan: directed scenarios plus random traffic against a timeline model.
module tb_peripheral_display_scan;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BF = 2;
  localparam int DW = 4 * N;
  localparam logic [31:0] DMASK = (32'd1 << DW) - 32'd1;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   display;
  logic         dp;
  logic [N-1:0] selector;

  peripheral_display_scan_if bus();

  peripheral_display_scan #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .display  (display),
    .dp       (dp),
    .selector (selector)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register contents, pending conversion and cycles since reset release
  logic [31:0] m_digits;
  logic [27:0] m_ctrl;
  int unsigned m_shadow;
  int unsigned m_pend;
  logic        m_ovf;
  int          busy_cnt;
  int          t;

  logic [6:0] seg_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_reset();
    m_digits = '0; m_ctrl = '0; m_shadow = 0; m_pend = 0;
    m_ovf = 1'b0; busy_cnt = 0; t = 0;
  endtask

  task automatic model_edge(input logic we, input logic a, input logic [31:0] wd);
    logic        start;
    int unsigned val;
    start = 1'b0;
    val   = 0;
    if (we) begin
      if (!a) begin
        if (m_ctrl[24]) begin start = 1'b1; val = wd & DMASK; end
        m_digits = wd & DMASK;
      end else begin
        if (!m_ctrl[24] && wd[24]) begin start = 1'b1; val = m_digits; end
        m_ctrl = wd[27:0];
      end
    end
    if (start) begin
      busy_cnt = DW;
      m_pend   = val;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        m_ovf    = (m_pend >= pow10(N));
        m_shadow = m_pend % pow10(N);
      end
    end
  endtask

  // One clock: outputs visible after the edge reflect the scan position and state before it
  task automatic tick(input logic we, input logic a, input logic [31:0] wd);
    logic [N-1:0] e_sel;
    logic [6:0]   e_disp;
    logic         e_dp;
    logic [31:0]  e_rd;
    int           p, idx, cyc, nib;
    logic         drv;
    rst = 1'b0; bus.WE = we; bus.A = a; bus.WD = wd;
    p   = t % (N * SD);
    idx = p / SD;
    cyc = p % SD;
    drv = m_ctrl[idx] && (cyc < ((int'(m_ctrl[27:25]) + 1) * SD) / 8);
`ifdef DISPLAY_SCAN_BLINK_EN
    if ((((t / (N * SD)) / BF) % 2) == 1 && m_ctrl[16 + idx]) drv = 1'b0;
`endif
    if (m_ctrl[24]) nib = int'((m_shadow / pow10(idx)) % 10);
    else            nib = int'((m_digits >> (4 * idx)) & 32'hF);
    e_sel  = drv ? ~(N'(1) << idx) : '1;
    e_disp = !drv ? 7'h7F : (m_ctrl[24] && m_ovf) ? 7'h3F : ~seg_hi[4'(nib)];
    e_dp   = !(drv && m_ctrl[8 + idx]);
    @(posedge clk);
    model_edge(we, a, wd);
    t++;
    #1;
    e_rd = a ? {busy_cnt != 0, m_ovf, 2'b00, m_ctrl} : m_digits;
    chk("selector", 32'(selector), 32'(e_sel));
    chk("display",  32'(display),  32'(e_disp));
    chk("dp",       32'(dp),       32'(e_dp));
    chk("rd",       bus.RD,        e_rd);
  endtask

  task automatic tick_rst(input logic a);
    rst = 1'b1; bus.WE = 1'($urandom % 2); bus.A = a; bus.WD = $urandom;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_selector", 32'(selector), 32'(4'hF));
    chk("rst_display",  32'(display),  32'h7F);
    chk("rst_dp",       32'(dp),       32'h1);
    chk("rst_rd",       bus.RD,        32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    logic [31:0] wd;
    logic        a;
    int          r;
    rst = 1'b1; bus.WE = 1'b0; bus.A = 1'b0; bus.WD = '0;
    model_reset();
    tick_rst(1'b0);
    tick_rst(1'b1);
    tick_rst(1'b0);

    // Plain hex scan at full brightness, then brightness 3
    tick(1'b1, 1'b0, 32'h0000_1234);
    tick(1'b1, 1'b1, 32'h0E00_000F);
    idle(70);
    tick(1'b1, 1'b1, 32'h0600_0F0F);
    idle(40);

    // Binary mode: 0->1 format switch converts 0x1234, then 1234 decimal
    tick(1'b1, 1'b1, 32'h0F00_000F);
    idle(20);
    tick(1'b1, 1'b0, 32'd1234);
    idle(40);

    // Overflow shows dashes; rewrite mid-conversion restarts with the new value
    tick(1'b1, 1'b0, 32'd10000);
    idle(40);
    tick(1'b1, 1'b0, 32'd10000);
    idle(5);
    tick(1'b1, 1'b0, 32'd5);
    idle(40);

    // Blink mask on digit 0 across several blink half-periods
    tick(1'b1, 1'b1, 32'h0E01_000F);
    idle(200);

    // Random register traffic with occasional resets
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      a = 1'($urandom % 2);
      wd = $urandom;
      if (r < 2) begin
        tick_rst(a);
      end else if (r < 20) begin
        if (!a && ($urandom % 2 == 1)) wd = $urandom_range(0, 12000);
        tick(1'b1, a, wd);
      end else begin
        tick(1'b0, a, wd);
      end
    end

    // Reset in the middle of a conversion and a slot
    tick(1'b1, 1'b1, 32'h0E00_000F);
    tick(1'b1, 1'b0, 32'd4321);
    tick(1'b1, 1'b1, 32'h0F00_00FF);
    idle(3);
    tick_rst(1'b1);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
